// File: rtl/mul_share_arbiter.sv
// Two-requester round-robin front end sharing one shift-add multiplier.
// One operation in flight at a time; the product is held until the consumer takes it.
module mul_share_arbiter #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           req1_ready,
  output logic           rsp_valid,
  output logic           rsp_id,
  output logic [2*W-1:0] rsp_p,
  input  logic           rsp_ready,
  output logic           busy
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] acc;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           owner;
  logic           last_served;
  logic           grant0, grant1;
  logic           accept;

  // last_served=1 after reset so requester 0 wins the first contested grant
  assign grant0 = req0_valid && (!req1_valid || last_served);
  assign grant1 = req1_valid && (!req0_valid || !last_served);
  assign accept = req0_ready || req1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    rsp_id     = 1'b0;
    rsp_p      = '0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy       = 1'b0;
        req0_ready = grant0 && !rst;
        req1_ready = grant1 && !rst;
        if (grant0 || grant1) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST_BIT) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_id    = owner;
        rsp_p     = acc;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operands are latched on accept, so requester inputs are free to change while busy
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
      owner       <= 1'b0;
      last_served <= 1'b1;
    end else if (accept) begin
      mcand       <= {{W{1'b0}}, (req1_ready ? req1_a : req0_a)};
      mplier      <= req1_ready ? req1_b : req0_b;
      acc         <= '0;
      cnt         <= '0;
      owner       <= req1_ready;
      last_served <= req1_ready;
    end else if (state == RUN) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: doc/mul_share_arbiter.md
MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the operand width; the product width SHALL be 2*W.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have the port req0_valid, input, 1 bit: requester 0 has an operation pending.
REQ-005 The block SHALL have the port req0_a / req0_b, input, W bits each: requester 0's unsigned operands.
REQ-006 The block SHALL have the port req0_ready, output, 1 bit: requester 0's operation is accepted on this edge if req0_valid=1.
REQ-007 The block SHALL have the ports req1_valid, req1_a, req1_b, req1_ready, with the same directions, widths and meanings as the requester 0 ports, for requester 1.
REQ-008 The block SHALL have the port rsp_valid, output, 1 bit: the product is available.
REQ-009 The block SHALL have the port rsp_id, output, 1 bit: the index of the requester that owns the product.
REQ-010 The block SHALL have the port rsp_p, output, 2W bits: the unsigned product.
REQ-011 The block SHALL have the port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-012 The block SHALL have the port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 The block SHALL contain one shared shift-add multiplier engine that retires one multiplier bit per cycle (test LSB, conditionally add the multiplicand, shift); no combinational multiplier is allowed.
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 IDLE -> RUN SHALL occur on an accept edge; RUN -> DONE SHALL occur after exactly W RUN edges; DONE -> IDLE SHALL occur on the edge where rsp_ready=1.
REQ-016 reqN_ready SHALL be combinational: 1 only when state=IDLE and the arbiter grants N; at most one ready is high in any cycle.
REQ-017 Arbitration SHALL be round-robin:
- only one requester valid -> grant it;
- both valid -> grant the requester not served last;
- the last-served pointer updates only on an accept edge.
REQ-018 On the accept edge, the block SHALL capture the operands and the owner id, clear the accumulator and set the bit counter to 0.
REQ-019 Latency: accept on edge E0 -> rsp_valid=1 after edge E0+W (8 for W=8), independent of the operand values, including zero operands.
REQ-020 In DONE, rsp_valid=1 and rsp_p/rsp_id SHALL hold stable until the edge where rsp_ready=1.
REQ-021 On the rsp_ready edge, rsp_valid SHALL fall on that edge; no new request is accepted on that edge.
REQ-022 Throughput: at most one operation per W+2 cycles, with back-to-back accepts separated by one IDLE cycle.
REQ-023 rsp_p SHALL equal the exact a*b, computed modulo nothing: no truncation and no overflow, for all 2^(2W) operand pairs.
REQ-024 reqN_valid may drop without acceptance (withdrawal); the arbiter SHALL re-evaluate every IDLE cycle.
REQ-025 Requester inputs SHALL be ignored while busy=1; operand changes during RUN SHALL NOT affect the result.
REQ-026 Outside DONE, rsp_p and rsp_id SHALL be 0.

Reset
REQ-027 When rst=1 at an edge, the block SHALL go to state IDLE and clear accumulator, counter and operand registers.
REQ-028 Reset SHALL set rsp_valid=0, rsp_p=0, rsp_id=0 and busy=0.
REQ-029 Reset SHALL set the round-robin pointer so that requester 0 wins the first contested grant.
REQ-030 Reset mid-RUN or in DONE SHALL abort the operation with no response produced.
REQ-031 While rst=1, both ready outputs SHALL be 0.

Verification
REQ-032 Directed scenario, single requester: req0 127x31 -> req0_ready on the first IDLE cycle; rsp_valid exactly 8 cycles after accept; rsp_id=0, rsp_p=3937 (0x0F61).
REQ-033 Directed scenario, contention: both valid from reset (req0 255x153, req1 3x2) -> req0 served first (rsp_p=39015); then req1 (rsp_id=1, rsp_p=6); then with both still valid, req0 again.
REQ-034 Directed scenario, backpressure: 255x255 with rsp_ready=0 for 5 cycles in DONE -> rsp_valid held and rsp_p=65025 stable; no ready asserted; release -> IDLE next cycle.
REQ-035 Directed scenario, reset mid-operation: rst=1 at the 4th RUN cycle of 143x245 -> next cycle busy=0, rsp_valid=0, no response ever issued; a following req1 15x185 returns 2775.
REQ-036 Directed scenario, operand edge cases: 0x0, 0xFF and 1x1 -> products 0, 0 and 1, each still with 8-cycle latency.
REQ-037 Directed scenario, randomized: 1000 random ops from both requesters with random rsp_ready -> every response matches the reference product; order matches the grant order; no request is lost or duplicated.
